// File: rtl/alu_cmd_sequencer.sv
// ============================================================================
// alu_cmd_sequencer
// ----------------------------------------------------------------------------
// Byte-stream command front end that sits directly upstream of a 16-bit ALU.
// Command frames arrive one byte per RX_VALID strobe. Operands and the
// function code are registered onto the ALU inputs. The ALU clock enable is
// opened for ALU_LATENCY cycles, ALU_OUT is captured, and the result is
// returned MSB first over a valid/busy byte handshake.
//
// Frames:
//   CMD_FULL  AH AL BH BL FUN : load both operands, then run
//   CMD_SHORT FUN             : reuse the stored operands, then run
//   FUN[7:4] must be zero, otherwise the frame is rejected with an ERR pulse.
//
// Handshake (TX side):
//   TX_VALID rises one cycle after a TX state is entered. A byte moves in
//   every cycle where TX_VALID=1 and TX_BUSY=0. While TX_BUSY=1, TX_VALID
//   and TX_DATA hold. After each transfer TX_VALID is low for at least one
//   cycle before the next byte is offered.
//
// Optional build feature (macro ALU_SEQ_FLAG_BYTE_EN):
//   defined   - a third byte {4'b0, ARITH, LOGIC, CMP, SHIFT} follows the
//               result bytes (state TX_FLG, same handshake).
//   undefined - two bytes only; the flag inputs are ignored.
//
// Parameters:
//   ALU_LATENCY  clock edges from stable ALU inputs to valid ALU_OUT (1..7)
//   CMD_FULL     command byte of a full frame
//   CMD_SHORT    command byte of a short frame
//
// Ports:
//   CLK, RST        clock, asynchronous active-high reset
//   RX_DATA/VALID   received byte and its one-cycle strobe
//   ALU_OUT         ALU result
//   *_FLAG          ALU op-class flags
//   OP_A, OP_B      ALU operands (registered)
//   ALU_FUN         ALU function code (registered)
//   ALU_EN          ALU clock-gate enable (registered)
//   TX_DATA/VALID   outgoing byte and offer strobe (registered)
//   TX_BUSY         sink cannot accept
//   ERR             one-cycle protocol error pulse (registered)
//   DBG_STATE       current FSM state, for observation only
// ============================================================================
module alu_cmd_sequencer #(
    parameter int unsigned ALU_LATENCY = 1,
    parameter logic [7:0]  CMD_FULL    = 8'hCC,
    parameter logic [7:0]  CMD_SHORT   = 8'hDD
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    input  logic [15:0] ALU_OUT,
    input  logic        ARITH_FLAG,
    input  logic        LOGIC_FLAG,
    input  logic        CMP_FLAG,
    input  logic        SHIFT_FLAG,
    output logic [15:0] OP_A,
    output logic [15:0] OP_B,
    output logic [3:0]  ALU_FUN,
    output logic        ALU_EN,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_BUSY,
    output logic        ERR,
    output logic [3:0]  DBG_STATE
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_RX_AH   = 4'd1,
        S_RX_AL   = 4'd2,
        S_RX_BH   = 4'd3,
        S_RX_BL   = 4'd4,
        S_RX_FUN  = 4'd5,
        S_ALU_RUN = 4'd6,
        S_CAPTURE = 4'd7,
        S_TX_HI   = 4'd8,
        S_TX_LO   = 4'd9
`ifdef ALU_SEQ_FLAG_BYTE_EN
        , S_TX_FLG = 4'd10
`endif
    } state_t;

    // The run counter is loaded with LATENCY-1 and ALU_EN drops on the edge
    // that sees it at zero, so ALU_EN is high for exactly ALU_LATENCY cycles.
    localparam logic [2:0] LAT_M1 = 3'(ALU_LATENCY - 1);

    state_t      state_q;
    logic [15:0] op_a_q;
    logic [15:0] op_b_q;
    logic [3:0]  fun_q;
    logic        alu_en_q;
    logic [2:0]  run_cnt_q;
    logic [15:0] result_q;
    logic [7:0]  tx_data_q;
    logic        tx_valid_q;
    logic        err_q;

`ifdef ALU_SEQ_FLAG_BYTE_EN
    logic [3:0]  flags_q;
`else
    logic        unused_flags;
    assign unused_flags = ^{ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG};
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            op_a_q     <= 16'h0000;
            op_b_q     <= 16'h0000;
            fun_q      <= 4'h0;
            alu_en_q   <= 1'b0;
            run_cnt_q  <= 3'd0;
            result_q   <= 16'h0000;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
`ifdef ALU_SEQ_FLAG_BYTE_EN
            flags_q    <= 4'h0;
`endif
        end else begin
            // ERR is a pulse: cleared every cycle unless an arm re-asserts it.
            err_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (RX_VALID) begin
                        if (RX_DATA == CMD_FULL) begin
                            state_q <= S_RX_AH;
                        end else if (RX_DATA == CMD_SHORT) begin
                            state_q <= S_RX_FUN;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end

                S_RX_AH: begin
                    if (RX_VALID) begin
                        op_a_q[15:8] <= RX_DATA;
                        state_q      <= S_RX_AL;
                    end
                end

                S_RX_AL: begin
                    if (RX_VALID) begin
                        op_a_q[7:0] <= RX_DATA;
                        state_q     <= S_RX_BH;
                    end
                end

                S_RX_BH: begin
                    if (RX_VALID) begin
                        op_b_q[15:8] <= RX_DATA;
                        state_q      <= S_RX_BL;
                    end
                end

                S_RX_BL: begin
                    if (RX_VALID) begin
                        op_b_q[7:0] <= RX_DATA;
                        state_q     <= S_RX_FUN;
                    end
                end

                S_RX_FUN: begin
                    if (RX_VALID) begin
                        if (RX_DATA[7:4] != 4'h0) begin
                            // Rejected: function code and ALU untouched,
                            // operand bytes already loaded are kept.
                            err_q   <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            fun_q     <= RX_DATA[3:0];
                            alu_en_q  <= 1'b1;
                            run_cnt_q <= LAT_M1;
                            state_q   <= S_ALU_RUN;
                        end
                    end
                end

                S_ALU_RUN: begin
                    if (RX_VALID) begin
                        err_q <= 1'b1;
                    end
                    if (run_cnt_q == 3'd0) begin
                        alu_en_q <= 1'b0;
                        state_q  <= S_CAPTURE;
                    end else begin
                        run_cnt_q <= run_cnt_q - 3'd1;
                    end
                end

                S_CAPTURE: begin
                    if (RX_VALID) begin
                        err_q <= 1'b1;
                    end
                    result_q <= ALU_OUT;
`ifdef ALU_SEQ_FLAG_BYTE_EN
                    flags_q  <= {ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG};
`endif
                    state_q  <= S_TX_HI;
                end

                // Each TX state: first cycle offers the byte, then waits for
                // a cycle with TX_BUSY low. Dropping TX_VALID on the transfer
                // edge gives the mandatory idle cycle in the next state.
                S_TX_HI: begin
                    if (RX_VALID) begin
                        err_q <= 1'b1;
                    end
                    if (!tx_valid_q) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= result_q[15:8];
                    end else if (!TX_BUSY) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= S_TX_LO;
                    end
                end

                S_TX_LO: begin
                    if (RX_VALID) begin
                        err_q <= 1'b1;
                    end
                    if (!tx_valid_q) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= result_q[7:0];
                    end else if (!TX_BUSY) begin
                        tx_valid_q <= 1'b0;
`ifdef ALU_SEQ_FLAG_BYTE_EN
                        state_q    <= S_TX_FLG;
`else
                        state_q    <= S_IDLE;
`endif
                    end
                end

`ifdef ALU_SEQ_FLAG_BYTE_EN
                S_TX_FLG: begin
                    if (RX_VALID) begin
                        err_q <= 1'b1;
                    end
                    if (!tx_valid_q) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= {4'b0000, flags_q};
                    end else if (!TX_BUSY) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
`endif

                default: begin
                    alu_en_q   <= 1'b0;
                    tx_valid_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign OP_A      = op_a_q;
    assign OP_B      = op_b_q;
    assign ALU_FUN   = fun_q;
    assign ALU_EN    = alu_en_q;
    assign TX_DATA   = tx_data_q;
    assign TX_VALID  = tx_valid_q;
    assign ERR       = err_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer. Two instances share clock and reset:
// u0 runs with ALU_LATENCY=1, u1 with ALU_LATENCY=3. Each has a bench-side
// pipelined ALU model clocked by its ALU_EN. Expected TX bytes are computed
// from the bench's own record of the operands and pushed when the function
// byte is driven; a monitor pops them on every TX transfer.
module tb_alu_cmd_sequencer;

    logic        clk;
    logic        rst;
    int          cyc;

    logic [7:0]  rx_data   [2];
    logic        rx_valid  [2];
    logic [15:0] alu_out   [2];
    logic [3:0]  alu_flg   [2];
    logic [15:0] op_a      [2];
    logic [15:0] op_b      [2];
    logic [3:0]  alu_fun   [2];
    logic        alu_en    [2];
    logic [7:0]  tx_data   [2];
    logic        tx_valid  [2];
    logic        tx_busy   [2];
    logic        err       [2];
    logic [3:0]  dbg_state [2];

    int          en_cnt    [2];
    int          err_cnt   [2];
    int          vld_cnt   [2];
    int          accept_cyc[2];
    logic [15:0] mdl_a     [2];
    logic [15:0] mdl_b     [2];

    logic [7:0]  exp_q[$];
    int          n_total;
    int          n_bad;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bench ALU model ----------------
    // Result in [15:0], flags {arith,logic,cmp,shift} in [19:16].
    function automatic logic [19:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [3:0] f);
        logic [15:0] r;
        logic [3:0]  fl;
        case (f)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a * b;
            4'd3:    r = a & b;
            4'd4:    r = a | b;
            4'd5:    r = a ^ b;
            default: r = a + b + {12'h000, f};
        endcase
        fl = {f < 4'd3, (f >= 4'd3) && (f <= 4'd5), a == b, f >= 4'd8};
        return {fl, r};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- DUTs, ALU models, monitors ----------------
    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;

        logic [19:0] pipe [LAT];
        logic        prev_v;
        logic        prev_b;
        logic [7:0]  prev_d;

        alu_cmd_sequencer #(.ALU_LATENCY(LAT)) u_dut (
            .CLK        (clk),
            .RST        (rst),
            .RX_DATA    (rx_data[g]),
            .RX_VALID   (rx_valid[g]),
            .ALU_OUT    (alu_out[g]),
            .ARITH_FLAG (alu_flg[g][3]),
            .LOGIC_FLAG (alu_flg[g][2]),
            .CMP_FLAG   (alu_flg[g][1]),
            .SHIFT_FLAG (alu_flg[g][0]),
            .OP_A       (op_a[g]),
            .OP_B       (op_b[g]),
            .ALU_FUN    (alu_fun[g]),
            .ALU_EN     (alu_en[g]),
            .TX_DATA    (tx_data[g]),
            .TX_VALID   (tx_valid[g]),
            .TX_BUSY    (tx_busy[g]),
            .ERR        (err[g]),
            .DBG_STATE  (dbg_state[g])
        );

        // ALU pipeline advances only on edges where ALU_EN is high.
        always @(posedge clk) begin
            if (alu_en[g]) begin
                pipe[0] <= alu_model(op_a[g], op_b[g], alu_fun[g]);
                for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
            end
        end
        assign alu_out[g] = pipe[LAT-1][15:0];
        assign alu_flg[g] = pipe[LAT-1][19:16];

        // Monitor: sampled mid-cycle, away from the active edge.
        always @(negedge clk) begin
            if (rst) begin
                prev_v <= 1'b0;
                prev_b <= 1'b0;
                prev_d <= 8'h00;
            end else begin
                if (alu_en[g])   en_cnt[g]  <= en_cnt[g] + 1;
                if (err[g])      err_cnt[g] <= err_cnt[g] + 1;
                if (tx_valid[g]) vld_cnt[g] <= vld_cnt[g] + 1;
                if (prev_v && prev_b) begin
                    check("hold_valid", {31'd0, tx_valid[g]}, 32'd1);
                    check("hold_data", {24'd0, tx_data[g]}, {24'd0, prev_d});
                end
                if (prev_v && !prev_b) begin
                    check("gap_after_xfer", {31'd0, tx_valid[g]}, 32'd0);
                end
                if (tx_valid[g] && !tx_busy[g]) begin
                    if (exp_q.size() == 0) begin
                        check("tx_unexpected", {24'd0, tx_data[g]}, 32'hFFFF_FFFF);
                    end else begin
                        check("tx_byte", {24'd0, tx_data[g]}, {24'd0, exp_q.pop_front()});
                    end
                end
                prev_v <= tx_valid[g];
                prev_b <= tx_busy[g];
                prev_d <= tx_data[g];
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input int g, input logic [7:0] b);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        @(posedge clk);
        #1;
        rx_data[g]  = b;
        rx_valid[g] = 1'b1;
        @(posedge clk);
        #1;
        rx_valid[g]   = 1'b0;
        accept_cyc[g] = cyc;
    endtask

    task automatic push_expected(input int g, input logic [3:0] f);
        logic [19:0] r;
        r = alu_model(mdl_a[g], mdl_b[g], f);
        exp_q.push_back(r[15:8]);
        exp_q.push_back(r[7:0]);
`ifdef ALU_SEQ_FLAG_BYTE_EN
        exp_q.push_back({4'b0000, r[19:16]});
`endif
    endtask

    task automatic run_full(input int g, input logic [15:0] a, input logic [15:0] b,
                            input logic [3:0] f);
        send_byte(g, 8'hCC);
        send_byte(g, a[15:8]);
        send_byte(g, a[7:0]);
        send_byte(g, b[15:8]);
        send_byte(g, b[7:0]);
        mdl_a[g] = a;
        mdl_b[g] = b;
        push_expected(g, f);
        send_byte(g, {4'h0, f});
    endtask

    task automatic run_short(input int g, input logic [3:0] f);
        send_byte(g, 8'hDD);
        push_expected(g, f);
        send_byte(g, {4'h0, f});
    endtask

    // Cycles from the function-byte accept edge to the first TX_VALID.
    task automatic check_latency(input int g, input int lat);
        int n;
        n = 0;
        while (!tx_valid[g] && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("first_tx_latency", cyc - accept_cyc[g], lat + 2);
    endtask

    task automatic wait_done(input int g);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && dbg_state[g] == 4'd0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("frame_done_timeout", {31'd0, n >= 300}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts(input int g);
        en_cnt[g]  = 0;
        err_cnt[g] = 0;
        vld_cnt[g] = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_total = 0;
        n_bad   = 0;
        cyc     = 0;
        rst     = 1'b1;
        for (int g = 0; g < 2; g++) begin
            rx_data[g]  = 8'h00;
            rx_valid[g] = 1'b0;
            tx_busy[g]  = 1'b0;
            mdl_a[g]    = 16'h0000;
            mdl_b[g]    = 16'h0000;
            clear_counts(g);
        end
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_op_a", {16'd0, op_a[0]}, 32'd0);
        check("rst_op_b", {16'd0, op_b[0]}, 32'd0);
        check("rst_fun", {28'd0, alu_fun[0]}, 32'd0);
        check("rst_alu_en", {31'd0, alu_en[0]}, 32'd0);
        check("rst_tx_valid", {31'd0, tx_valid[0]}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data[0]}, 32'd0);
        check("rst_err", {31'd0, err[0]}, 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 1: full frame, add, latency 1 -> TX 00 04
        clear_counts(0);
        run_full(0, 16'h0003, 16'h0001, 4'h0);
        check_latency(0, 1);
        wait_done(0);
        check("s1_op_a", {16'd0, op_a[0]}, 32'h0003);
        check("s1_op_b", {16'd0, op_b[0]}, 32'h0001);
        check("s1_fun", {28'd0, alu_fun[0]}, 32'h0);
        check("s1_en_cycles", en_cnt[0], 1);
        check("s1_err", err_cnt[0], 0);

        // 2: short frame reuses 3/1, multiply -> 3*1 = 0003
        clear_counts(0);
        run_short(0, 4'h2);
        wait_done(0);
        check("s2_op_a", {16'd0, op_a[0]}, 32'h0003);
        check("s2_op_b", {16'd0, op_b[0]}, 32'h0001);
        check("s2_fun", {28'd0, alu_fun[0]}, 32'h2);
        check("s2_en_cycles", en_cnt[0], 1);

        // 3: junk byte in IDLE, then a normal frame (xor)
        clear_counts(0);
        send_byte(0, 8'h55);
        repeat (4) @(posedge clk);
        #1;
        check("s3_err_pulse", err_cnt[0], 1);
        check("s3_no_en", en_cnt[0], 0);
        check("s3_no_tx", vld_cnt[0], 0);
        run_full(0, 16'h1234, 16'h0F0F, 4'h5);
        wait_done(0);
        check("s3_err_after", err_cnt[0], 1);
        check("s3_en_cycles", en_cnt[0], 1);

        // 4: bad function byte 1F -> ERR, no ALU run, FUN keeps 5
        clear_counts(0);
        send_byte(0, 8'hCC);
        send_byte(0, 8'h00);
        send_byte(0, 8'h07);
        send_byte(0, 8'h00);
        send_byte(0, 8'h01);
        send_byte(0, 8'h1F);
        mdl_a[0] = 16'h0007;
        mdl_b[0] = 16'h0001;
        repeat (6) @(posedge clk);
        #1;
        check("s4_err_pulse", err_cnt[0], 1);
        check("s4_no_en", en_cnt[0], 0);
        check("s4_state_idle", {28'd0, dbg_state[0]}, 32'd0);
        check("s4_fun_kept", {28'd0, alu_fun[0]}, 32'h5);
        check("s4_op_a", {16'd0, op_a[0]}, 32'h0007);
        check("s4_no_tx", vld_cnt[0], 0);

        // 5: latency 3, sink busy 20 cycles at TX_HI, one byte injected
        clear_counts(1);
        tx_busy[1] = 1'b1;
        run_full(1, 16'h0010, 16'h0020, 4'h0);
        check_latency(1, 3);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) send_byte(1, 8'h77);
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("s5_en_cycles", en_cnt[1], 3);
        check("s5_err_inject", err_cnt[1], 1);
        check("s5_valid_held", {31'd0, tx_valid[1]}, 32'd1);
        check("s5_data_held", {24'd0, tx_data[1]}, 32'h00);
        check("s5_pending", exp_q.size(), 2 + ((exp_q.size() == 3) ? 1 : 0));
        tx_busy[1] = 1'b0;
        wait_done(1);
        check("s5_err_final", err_cnt[1], 1);

        // 6: reset while in RX_BL, then short frame on cleared operands
        send_byte(0, 8'hCC);
        send_byte(0, 8'h11);
        send_byte(0, 8'h22);
        send_byte(0, 8'h33);
        @(negedge clk);
        check("s6_pre_rst_op_a", {16'd0, op_a[0]}, 32'h1122);
        #2;
        rst = 1'b1;
        #1;
        check("s6_rst_op_a", {16'd0, op_a[0]}, 32'd0);
        check("s6_rst_op_b", {16'd0, op_b[0]}, 32'd0);
        check("s6_rst_fun", {28'd0, alu_fun[0]}, 32'd0);
        check("s6_rst_state", {28'd0, dbg_state[0]}, 32'd0);
        check("s6_rst_tx_data", {24'd0, tx_data[0]}, 32'd0);
        check("s6_rst_err", {31'd0, err[0]}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mdl_a[0] = 16'h0000;
        mdl_b[0] = 16'h0000;
        clear_counts(0);
        run_short(0, 4'hA);
        wait_done(0);
        check("s6_op_a", {16'd0, op_a[0]}, 32'd0);
        check("s6_op_b", {16'd0, op_b[0]}, 32'd0);
        check("s6_fun", {28'd0, alu_fun[0]}, 32'hA);
        check("s6_err", err_cnt[0], 0);

        // Random full frames on both latencies
        for (int k = 0; k < 6; k++) begin
            int g;
            g = k % 2;
            run_full(g, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                     4'($urandom_range(0, 15)));
            wait_done(g);
        end

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
